// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Sits downstream of the 4-input MAC PE. For each output pixel it seeds the
//   accumulator with a bias, adds cfg_num_acc signed partial sums with
//   saturation, then requantizes the total with a rounding right shift and
//   clamps it to an 8-bit activation.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             begin a pixel (sampled only in IDLE)
//   cfg_num_acc       partial sums to accumulate (0 behaves as 1)
//   cfg_bias          signed initial accumulator value
//   cfg_shift         requantization right shift, 0..31
//   psum_valid/ready  partial-sum input handshake, psum_in signed
//   out_valid/ready   result handshake
//   out_data          signed 8-bit requantized activation
//   out_acc           raw accumulator total
//   busy              FSM not in IDLE
//
// Build option
//   PSUM_ACC_RELU_EN  when defined, negative requantized results become 0.
module psum_accumulator #(
    parameter int PSUM_W = 25,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_num_acc,
    input  logic signed [ACC_W-1:0]  cfg_bias,
    input  logic [4:0]               cfg_shift,
    input  logic                     psum_valid,
    input  logic signed [PSUM_W-1:0] psum_in,
    output logic                     psum_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [7:0]        out_data,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, QUANT, OUT} state_t;

    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] Q_MIN = -(ACC_W+1)'(128);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic [4:0]              shift;

    // Accumulate one bit wider so overflow shows up as a sign/MSB disagreement.
    logic signed [ACC_W:0]   sum_ext;
    logic signed [ACC_W-1:0] acc_sat;

    always_comb begin
        sum_ext = {acc[ACC_W-1], acc} + (ACC_W+1)'(psum_in);
        acc_sat = sum_ext[ACC_W-1:0];
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1])
            acc_sat = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
    end

    // Round-half-up right shift; the extra bit keeps acc + 2^(shift-1) exact.
    logic signed [ACC_W:0] rnd_bias;
    logic signed [ACC_W:0] rnd_sum;
    logic signed [ACC_W:0] r;
    logic signed [7:0]     q;

    always_comb begin
        rnd_bias = '0;
        if (shift != 5'd0)
            rnd_bias = (ACC_W+1)'(1) << (shift - 5'd1);
        rnd_sum = {acc[ACC_W-1], acc} + rnd_bias;
        r       = rnd_sum >>> shift;
        q       = r[7:0];
`ifdef PSUM_ACC_RELU_EN
        if (r < 0)
            q = '0;
        else if (r > Q_MAX)
            q = 8'sd127;
`else
        if (r > Q_MAX)
            q = 8'sd127;
        else if (r < Q_MIN)
            q = -8'sd128;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            shift    <= '0;
            out_data <= '0;
            out_acc  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc   <= cfg_bias;
                    cnt   <= (cfg_num_acc == '0) ? CNT_W'(1) : cfg_num_acc;
                    shift <= cfg_shift;
                    state <= ACCUM;
                end
                ACCUM: if (psum_valid) begin
                    acc <= acc_sat;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= QUANT;
                end
                QUANT: begin
                    out_data <= q;
                    out_acc  <= acc;
                    state    <= OUT;
                end
                OUT: if (out_ready)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags depend on the state register only.
    assign psum_ready = (state == ACCUM);
    assign out_valid  = (state == OUT);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        cfg_num_acc;
    logic signed [31:0] cfg_bias;
    logic [4:0]        cfg_shift;
    logic              psum_valid;
    logic signed [24:0] psum_in;
    logic              psum_ready;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic signed [31:0] out_acc;
    logic              busy;

    psum_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_acc(cfg_num_acc),
        .cfg_bias(cfg_bias), .cfg_shift(cfg_shift), .psum_valid(psum_valid),
        .psum_in(psum_in), .psum_ready(psum_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_acc(out_acc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int     ps[4];
    longint exp_acc[$];
    int     exp_dat[$];

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic model(input longint bias, input int num, input int sh,
                         output longint a, output int d);
        longint r;
        int n;
        n = (num == 0) ? 1 : num;
        a = bias;
        for (int i = 0; i < n; i++) a = sat32(a + longint'(ps[i]));
        r = a;
        if (sh > 0) r = r + (64'sd1 <<< (sh - 1));
        r = r >>> sh;
`ifdef PSUM_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        d = int'(r);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_acc.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_acc", out_acc, exp_acc[0]);
                    chk("out_data", out_data, exp_dat[0]);
                    chk("psum_ready_in_out", psum_ready, 0);
                    if (out_ready) begin
                        void'(exp_acc.pop_front());
                        void'(exp_dat.pop_front());
                    end
                end
            end
            if ((out_valid || psum_ready) && !busy) chk("busy_flag", busy, 1);
        end
    end

    // ---------------- stimulus ----------------
    // Called at #1 after a rising edge with the DUT in IDLE; returns at #1
    // after the output handshake edge so the next call is back-to-back.
    task automatic run_pixel(input longint bias, input int num, input int sh,
                             input int gap, input int stall, input bit ign_start,
                             input bit time_chk, input int abort_after);
        longint a;
        int d, n, c0, k;
        bit hs;
        n = (num == 0) ? 1 : num;
        model(bias, num, sh, a, d);
        exp_acc.push_back(a);
        exp_dat.push_back(d);
        out_ready   = (stall == 0);
        start       = 1'b1;
        cfg_bias    = 32'(bias);
        cfg_num_acc = 8'(num);
        cfg_shift   = 5'(sh);
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_bias = 32'h5a5a5a5a; cfg_num_acc = 8'hff; cfg_shift = 5'd17;
        for (int i = 0; i < n; i++) begin
            psum_valid = 1'b1;
            psum_in    = 25'(ps[i]);
            k = 0;
            do begin
                @(negedge clk); hs = psum_ready;
                @(posedge clk); #1;
                k++;
            end while (!hs && k < 64);
            if (!hs) begin
                chk("accept_timeout", 0, 1);
                psum_valid = 1'b0;
                return;
            end
            if (abort_after > 0 && i + 1 == abort_after) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_psum_ready", psum_ready, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_out_acc", out_acc, 0);
                exp_acc.delete(); exp_dat.delete();
                psum_valid = 1'b0;
                @(negedge clk) rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (gap > 0 && i + 1 < n) begin
                psum_valid = 1'b0;
                psum_in    = 25'sd12345;
                @(posedge clk); #1;
            end
        end
        psum_valid = 1'b0;
        @(negedge clk);
        chk("quant_out_valid", out_valid, 0);
        chk("quant_psum_ready", psum_ready, 0);
        @(negedge clk);
        chk("out_valid_latency", out_valid, 1);
        if (!out_valid) return;
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                start      = ign_start && (s == 0);
                psum_valid = 1'b1;
                psum_in    = 25'sd999;
            end
            start = 1'b0; psum_valid = 1'b0; out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_after_out", busy, 0);
        if (time_chk) chk("pixel_cycles", cyc - c0, n + 3);
    endtask

    longint la;
    int     ld;

    initial begin
        rst = 1'b1; start = 1'b0; cfg_num_acc = '0; cfg_bias = '0; cfg_shift = '0;
        psum_valid = 1'b0; psum_in = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_psum_ready", psum_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_acc", out_acc, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic accumulate and round: 1000 + 8 = 1008 >> 4 = 63
        ps = '{100, 200, 300, 400};
        model(0, 4, 4, la, ld);
        chk("lit_basic_acc", la, 1000);
        chk("lit_basic_dat", ld, 63);
        run_pixel(0, 4, 4, 0, 0, 0, 1, 0);

        // negative total: (-1000 + 8) >>> 4 = -62
        ps = '{-1000, 0, 0, 0};
        model(0, 1, 4, la, ld);
        chk("lit_neg_acc", la, -1000);
`ifdef PSUM_ACC_RELU_EN
        chk("lit_neg_dat", ld, 0);
`else
        chk("lit_neg_dat", ld, -62);
`endif
        run_pixel(0, 1, 4, 0, 0, 0, 1, 0);

        // count 0 acts as 1, output saturates high
        ps = '{10000, 777, 0, 0};
        model(50, 0, 0, la, ld);
        chk("lit_cnt0_acc", la, 10050);
        chk("lit_cnt0_dat", ld, 127);
        run_pixel(50, 0, 0, 0, 0, 0, 1, 0);

        // accumulator saturation at both rails
        ps = '{1, 5, 0, 0};
        model(64'sd2147483647, 2, 0, la, ld);
        chk("lit_satp_acc", la, 2147483647);
        run_pixel(64'sd2147483647, 2, 0, 0, 0, 0, 1, 0);
        ps = '{-1, 0, 0, 0};
        model(-64'sd2147483648, 1, 31, la, ld);
        chk("lit_satn_acc", la, -64'sd2147483648);
`ifdef PSUM_ACC_RELU_EN
        chk("lit_satn_dat", ld, 0);
`else
        chk("lit_satn_dat", ld, -1);
`endif
        run_pixel(-64'sd2147483648, 1, 31, 0, 0, 0, 1, 0);

        // gapped input, stalled output, start pulse in OUT ignored
        ps = '{5, -20, 3, 0};
        model(-7, 3, 1, la, ld);
        chk("lit_bp_acc", la, -19);
`ifdef PSUM_ACC_RELU_EN
        chk("lit_bp_dat", ld, 0);
`else
        chk("lit_bp_dat", ld, -9);
`endif
        run_pixel(-7, 3, 1, 1, 3, 1, 0, 0);

        // reset after 2 of 4 sums, then a fresh pixel and a back-to-back one
        ps = '{10, 20, 30, 40};
        run_pixel(0, 4, 0, 0, 0, 0, 0, 2);
        ps = '{9, 6, 0, 0};
        model(1, 2, 2, la, ld);
        chk("lit_post_rst_acc", la, 16);
        chk("lit_post_rst_dat", ld, 4);
        run_pixel(1, 2, 2, 0, 0, 0, 1, 0);
        ps = '{-300, 40, -2, 7};
        run_pixel(100, 4, 2, 0, 1, 0, 0, 0);

        chk("queue_drained", exp_acc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
